mul_master_sequencer: RTL and testbench

Master sequencer for the digit-serial multiplier, directly upstream of the multiplier computation control. On a start request it produces the 9-bit master count `cnt_master` and the `write_enable` qualifier that the computation control consumes. Each operand digit occupies four counts. The block supports stalling, aborting and a start/busy/done handshake with the Newton-iteration controller.

---
 rtl/mul_seq_pkg.sv | 16 +
 rtl/mul_seq_stall_counter.sv | 21 ++
 rtl/mul_master_sequencer.sv | 128 ++++++++++++
 tb/tb_mul_master_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the multiplier master sequencer.
package mul_seq_pkg;

  localparam int DIGIT_W_DEF = 7;
  localparam int CNT_W_DEF   = 9;
  // Each operand digit occupies 2**DIGIT_SHIFT master counts.
  localparam int DIGIT_SHIFT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/mul_seq_stall_counter.sv
// 16-bit saturating event counter with synchronous clear; used for stall
// accounting when MUL_SEQ_STALL_CNT_EN is defined.
module mul_seq_stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/mul_master_sequencer.sv
// Master count sequencer for the digit-serial multiplier. Optional stall
// accounting is built only when MUL_SEQ_STALL_CNT_EN is defined.
module mul_master_sequencer
  import mul_seq_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT_W-1:0] len_m1,
  input  logic               hold,
  input  logic               abort,
  output logic [CNT_W-1:0]   cnt_master,
  output logic               write_enable,
  output logic               busy,
  output logic               done,
  output logic               last_digit,
  output logic [15:0]        stall_cycles
);

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   term_cnt;
  logic               we_d, busy_d, done_d, last_d;

  assign term_cnt = {len_q, {DIGIT_SHIFT{1'b1}}};

  // All outputs are registered: the next-state logic computes their values
  // for the state being entered, so they change together with the state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = '0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_PRIME;
          len_d   = len_m1;
          busy_d  = 1'b1;
        end
      end
      S_PRIME: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          we_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hold) begin
          busy_d = 1'b1;
          cnt_d  = cnt_master;
        end else if (cnt_master == term_cnt) begin
          state_d = S_DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = cnt_master;
        end else begin
          busy_d = 1'b1;
          we_d   = 1'b1;
          cnt_d  = cnt_master + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    last_d = (state_d == S_RUN) && (cnt_d[CNT_W-1:DIGIT_SHIFT] == len_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_master   <= '0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      last_digit   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_master   <= cnt_d;
      write_enable <= we_d;
      busy         <= busy_d;
      done         <= done_d;
      last_digit   <= last_d;
    end
  end

`ifdef MUL_SEQ_STALL_CNT_EN
  logic stall_clr;
  logic stall_inc;

  // An abort returns every output to its reset value, the stall count included.
  assign stall_clr = ((state_q == S_IDLE) && start && !abort) ||
                     ((state_q != S_IDLE) && abort);
  assign stall_inc = (state_q == S_RUN) && hold && !abort;

  mul_seq_stall_counter u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (stall_clr),
    .inc   (stall_inc),
    .count (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mul_master_sequencer.sv
// Directed scoreboard bench for mul_master_sequencer; expected per-cycle
// outputs are queued as stimulus is driven and compared after each edge.
module tb_mul_master_sequencer;

  typedef struct packed {
    logic [8:0] cnt;
    logic       we;
    logic       busy;
    logic       done;
    logic       last;
  } exp_t;

`ifdef MUL_SEQ_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd3;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len_m1;
  logic        hold;
  logic        abort;
  logic [8:0]  cnt_master;
  logic        write_enable;
  logic        busy;
  logic        done;
  logic        last_digit;
  logic [15:0] stall_cycles;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  exp_t sb[$];

  mul_master_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len_m1       (len_m1),
    .hold         (hold),
    .abort        (abort),
    .cnt_master   (cnt_master),
    .write_enable (write_enable),
    .busy         (busy),
    .done         (done),
    .last_digit   (last_digit),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int c, input logic we, input logic bz,
                              input logic dn, input logic lst);
    exp_t e;
    e.cnt  = 9'(c);
    e.we   = we;
    e.busy = bz;
    e.done = dn;
    e.last = lst;
    return e;
  endfunction

  function automatic logic run_last(input int c, input int len);
    return (c / 4) == len;
  endfunction

  // Queue the expectation for the coming edge, clock once, then compare.
  task automatic cyc(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = sb.pop_front();
    check("cnt_master",   32'(cnt_master),   32'(got.cnt));
    check("write_enable", 32'(write_enable), 32'(got.we));
    check("busy",         32'(busy),         32'(got.busy));
    check("done",         32'(done),         32'(got.done));
    check("last_digit",   32'(last_digit),   32'(got.last));
  endtask

  // Full run from IDLE; optional hold burst after count hold_at is shown and
  // an optional spurious start (with another length) while showing spur_at.
  task automatic run_seq(input int len, input int hold_at, input int hold_n,
                         input int spur_at, input int spur_len);
    int term;
    term   = 4 * (len + 1) - 1;
    start  = 1'b1;
    len_m1 = 7'(len);
    cyc(mk(0, 1'b0, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    for (int c = 0; c <= term; c++) begin
      if (c == spur_at) begin
        start  = 1'b1;
        len_m1 = 7'(spur_len);
      end else begin
        start = 1'b0;
      end
      cyc(mk(c, 1'b1, 1'b1, 1'b0, run_last(c, len)));
      start = 1'b0;
      if (c == hold_at) begin
        hold = 1'b1;
        for (int h = 0; h < hold_n; h++) cyc(mk(c, 1'b0, 1'b1, 1'b0, run_last(c, len)));
        hold = 1'b0;
      end
    end
    cyc(mk(term, 1'b0, 1'b1, 1'b1, 1'b0));
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    len_m1 = '0;
    hold   = 1'b0;
    abort  = 1'b0;
    #12;
    check("reset cnt_master",   32'(cnt_master),   32'd0);
    check("reset write_enable", 32'(write_enable), 32'd0);
    check("reset busy",         32'(busy),         32'd0);
    check("reset done",         32'(done),         32'd0);
    check("reset last_digit",   32'(last_digit),   32'd0);
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Shortest run: counts 0..3, done, back to idle.
    run_seq(0, -1, 0, -1, 0);

    // Longest run: 0..511 without wrap, last_digit over 508..511.
    run_seq(127, -1, 0, -1, 0);

    // Three-cycle stall while count 5 is shown.
    run_seq(2, 5, 3, -1, 0);
    check("stall_cycles after hold", 32'(stall_cycles), 32'(EXP_STALL));
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("stall_cycles held in idle", 32'(stall_cycles), 32'(EXP_STALL));

    // Start pulsed mid-run with a different length is ignored.
    run_seq(1, -1, 0, 2, 5);

    // Abort together with hold while count 7 is shown.
    start  = 1'b1;
    len_m1 = 7'd3;
    cyc(mk(0, 1'b0, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    for (int c = 0; c <= 7; c++) cyc(mk(c, 1'b1, 1'b1, 1'b0, 1'b0));
    hold  = 1'b1;
    abort = 1'b1;
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    hold  = 1'b0;
    abort = 1'b0;
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset while count 100 is shown, then a normal run.
    start  = 1'b1;
    len_m1 = 7'd127;
    cyc(mk(0, 1'b0, 1'b1, 1'b0, 1'b0));
    start = 1'b0;
    for (int c = 0; c <= 100; c++) cyc(mk(c, 1'b1, 1'b1, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("async rst cnt_master",   32'(cnt_master),   32'd0);
    check("async rst write_enable", 32'(write_enable), 32'd0);
    check("async rst busy",         32'(busy),         32'd0);
    check("async rst last_digit",   32'(last_digit),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(mk(0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_seq(1, -1, 0, -1, 0);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
